// File: rtl/ucsbece154a_instr_encoder.sv
// Assembles symbolic RV32I requests into machine words and writes them to instruction memory.
// Optional macro UCSBECE154A_ENC_RANGECHK_EN rejects out-of-range immediates instead of truncating.
module ucsbece154a_instr_encoder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      kind_i,
    input  logic [2:0]      alu_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [31:0]     imm_i,
    input  logic            clear_i,
    output logic            we_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic            ack_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            err_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEnc   = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    localparam logic [2:0] KindLw   = 3'b000;
    localparam logic [2:0] KindSw   = 3'b001;
    localparam logic [2:0] KindR    = 3'b010;
    localparam logic [2:0] KindBeq  = 3'b011;
    localparam logic [2:0] KindIAlu = 3'b100;
    localparam logic [2:0] KindJal  = 3'b101;
    localparam logic [2:0] KindLui  = 3'b110;

    logic [1:0]      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;
    logic            clr_pend_q, clr_pend_d;
    logic [2:0]      kind_q, alu_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [31:0]     imm_q;
    logic            accept;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_ok;
    logic        illegal;
    logic [31:0] word;

    always_comb begin
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        alu_ok = 1'b1;
        case (alu_q)
            3'b000:  funct3 = 3'b000;
            3'b001:  funct7 = 7'b0100000;
            3'b010:  funct3 = 3'b111;
            3'b011:  funct3 = 3'b110;
            3'b101:  funct3 = 3'b010;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (kind_q)
            KindLw:   word = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            KindSw:   word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            KindR: begin
                word    = {funct7, rs2_q, rs1_q, funct3, rd_q, 7'b0110011};
                illegal = ~alu_ok;
            end
            KindBeq:  word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1],
                              imm_q[11], 7'b1100011};
            KindIAlu: begin
                word    = {imm_q[11:0], rs1_q, funct3, rd_q, 7'b0010011};
                illegal = ~alu_ok | (alu_q == 3'b001);
            end
            KindJal:  word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
            KindLui:  word = {imm_q[31:12], rd_q, 7'b0110111};
            default:  illegal = 1'b1;
        endcase
`ifdef UCSBECE154A_ENC_RANGECHK_EN
        // An immediate fits when every bit above the field's sign bit equals that sign bit.
        case (kind_q)
            KindLw, KindSw, KindIAlu:
                if (!(&imm_q[31:11] || ~|imm_q[31:11])) illegal = 1'b1;
            KindBeq:
                if (imm_q[0] || !(&imm_q[31:12] || ~|imm_q[31:12])) illegal = 1'b1;
            KindJal:
                if (imm_q[0] || !(&imm_q[31:20] || ~|imm_q[31:20])) illegal = 1'b1;
            KindLui:
                if (|imm_q[11:0]) illegal = 1'b1;
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        clr_pend_d = clr_pend_q;
        accept     = 1'b0;
        case (state_q)
            StIdle: begin
                // A clear deferred from ENC/WRITE lands here, after the write finished.
                if (clear_i || clr_pend_q) begin
                    addr_d     = BASE_ADDR;
                    count_d    = '0;
                    clr_pend_d = 1'b0;
                end else if (valid_i && !full_o) begin
                    accept  = 1'b1;
                    state_d = StEnc;
                end
            end
            StEnc: begin
                if (clear_i) clr_pend_d = 1'b1;
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdata_d = word;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (clear_i) clr_pend_d = 1'b1;
                if (ack_i) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + CntW'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'h0;
            count_q    <= '0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            kind_q     <= 3'b000;
            alu_q      <= 3'b000;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            imm_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            clr_pend_q <= clr_pend_d;
            if (accept) begin
                kind_q <= kind_i;
                alu_q  <= alu_i;
                rd_q   <= rd_i;
                rs1_q  <= rs1_i;
                rs2_q  <= rs2_i;
                imm_q  <= imm_i;
            end
        end
    end

    assign full_o  = (count_q == CntW'(DEPTH));
    assign ready_o = (state_q == StIdle) & ~full_o & ~clr_pend_q;
    assign we_o    = (state_q == StWrite);
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ucsbece154a_instr_encoder.sv
// Directed self-checking bench for ucsbece154a_instr_encoder (DEPTH=4, BASE_ADDR=0).
module tb_ucsbece154a_instr_encoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  kind_i = 3'b0;
    logic [2:0]  alu_i = 3'b0;
    logic [4:0]  rd_i = 5'd0;
    logic [4:0]  rs1_i = 5'd0;
    logic [4:0]  rs2_i = 5'd0;
    logic [31:0] imm_i = 32'h0;
    logic        clear_i = 1'b0;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        ack_i = 1'b0;
    logic [2:0]  count_o;
    logic        full_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ucsbece154a_instr_encoder #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .kind_i    (kind_i),
        .alu_i     (alu_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .clear_i   (clear_i),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .ack_i     (ack_i),
        .count_o   (count_o),
        .full_o    (full_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for a single accepting edge; returns with the DUT in ENC.
    task automatic send(input logic [2:0] kind, input logic [2:0] alu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        kind_i  = kind;
        alu_i   = alu;
        rd_i    = rd;
        rs1_i   = rs1;
        rs2_i   = rs2;
        imm_i   = imm;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] exp_addr,
                                input logic [31:0] exp_word, input int exp_count);
        int n = 0;
        while (!we_o && n < 5) begin
            step();
            n++;
        end
        check_eq({tag, "_we"}, 32'(we_o), 32'd1);
        check_eq({tag, "_addr"}, addr_o, exp_addr);
        check_eq({tag, "_word"}, wdata_o, exp_word);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check_eq({tag, "_count"}, 32'(count_o), 32'(exp_count));
        check_eq({tag, "_next"}, addr_o, exp_addr + 32'd4);
    endtask

    task automatic expect_reject(input string tag, input logic [31:0] exp_addr, input int exp_count);
        step();
        check_eq({tag, "_err"}, 32'(err_o), 32'd1);
        check_eq({tag, "_we"}, 32'(we_o), 32'd0);
        step();
        check_eq({tag, "_err_end"}, 32'(err_o), 32'd0);
        check_eq({tag, "_addr"}, addr_o, exp_addr);
        check_eq({tag, "_count"}, 32'(count_o), 32'(exp_count));
    endtask

    initial begin
        #12;
        check_eq("rst_ready", 32'(ready_o), 32'd1);
        check_eq("rst_we", 32'(we_o), 32'd0);
        check_eq("rst_addr", addr_o, 32'h0);
        check_eq("rst_count", 32'(count_o), 32'd0);
        reset_n_i = 1'b1;
        step();

        send(3'b100, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_write("addi", 32'h0, 32'h0050_0093, 1);
        send(3'b010, 3'b001, 5'd3, 5'd1, 5'd2, 32'h0);
        expect_write("sub", 32'h4, 32'h4020_81B3, 2);
        send(3'b011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8);
        expect_write("beq", 32'h8, 32'hFE20_8CE3, 3);
        send(3'b101, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16);
        expect_write("jal", 32'hC, 32'h0100_00EF, 4);

        // Full: a held request must be ignored.
        check_eq("full", 32'(full_o), 32'd1);
        kind_i  = 3'b100;
        valid_i = 1'b1;
        step();
        check_eq("full_ready", 32'(ready_o), 32'd0);
        step();
        step();
        check_eq("full_no_we", 32'(we_o), 32'd0);
        check_eq("full_count", 32'(count_o), 32'd4);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        valid_i = 1'b0;
        check_eq("clr_count", 32'(count_o), 32'd0);
        check_eq("clr_addr", addr_o, 32'h0);
        check_eq("clr_ready", 32'(ready_o), 32'd1);
        check_eq("clr_full", 32'(full_o), 32'd0);
        check_eq("clr_no_we", 32'(we_o), 32'd0);

        send(3'b110, 3'b111, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        expect_write("lui", 32'h0, 32'h1234_52B7, 1);
        send(3'b000, 3'b011, 5'd6, 5'd2, 5'd0, 32'd8);
        expect_write("lw", 32'h4, 32'h0081_2303, 2);

        send(3'b100, 3'b001, 5'd1, 5'd1, 5'd0, 32'd1);
        expect_reject("isub", 32'h8, 2);
        send(3'b111, 3'b000, 5'd1, 5'd1, 5'd0, 32'd1);
        expect_reject("kind7", 32'h8, 2);
        send(3'b010, 3'b100, 5'd1, 5'd1, 5'd2, 32'd0);
        expect_reject("alu4", 32'h8, 2);

        send(3'b011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3);
`ifdef UCSBECE154A_ENC_RANGECHK_EN
        expect_reject("beq_odd", 32'h8, 2);
`else
        expect_write("beq_odd", 32'h8, 32'h0020_8163, 3);
`endif

        // Asynchronous reset while a write waits for ack.
        send(3'b000, 3'b000, 5'd6, 5'd2, 5'd0, 32'd8);
        step();
        check_eq("pre_rst_we", 32'(we_o), 32'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("arst_we", 32'(we_o), 32'd0);
        check_eq("arst_ready", 32'(ready_o), 32'd1);
        check_eq("arst_addr", addr_o, 32'h0);
        check_eq("arst_wdata", wdata_o, 32'h0);
        check_eq("arst_count", 32'(count_o), 32'd0);
        check_eq("arst_full", 32'(full_o), 32'd0);
        check_eq("arst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
